// File: rtl/bus_pkg.sv
// Shared bus codes, command format and sequencer state encoding for the
// 8-bit datapath bus (Bus_mux, register file and bus_xfer_ctrl).
package bus_pkg;

  localparam logic [3:0] CODE_NONE = 4'd0;
  localparam logic [3:0] CODE_AC   = 4'd1;
  localparam logic [3:0] CODE_C3   = 4'd2;
  localparam logic [3:0] CODE_C2   = 4'd3;
  localparam logic [3:0] CODE_C1   = 4'd4;
  localparam logic [3:0] CODE_RN2  = 4'd5;
  localparam logic [3:0] CODE_RK2  = 4'd6;
  localparam logic [3:0] CODE_RM2  = 4'd7;
  localparam logic [3:0] CODE_RN1  = 4'd8;
  localparam logic [3:0] CODE_RK1  = 4'd9;
  localparam logic [3:0] CODE_RM1  = 4'd10;
  localparam logic [3:0] CODE_RT   = 4'd11;
  localparam logic [3:0] CODE_RP   = 4'd12;
  localparam logic [3:0] CODE_DR   = 4'd13;
  localparam logic [3:0] CODE_AR   = 4'd14;
  localparam logic [3:0] CODE_MEM  = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_LOAD} xfer_state_t;

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] dst;
  } bus_cmd_t;

  function automatic logic [15:0] code_onehot(input logic [3:0] code);
    return 16'h0001 << code;
  endfunction

  function automatic logic cmd_illegal(input bus_cmd_t c);
    return (c.src == CODE_NONE) || (c.dst == CODE_NONE) || (c.src == c.dst);
  endfunction

endpackage

// File: rtl/bus_cmd_fifo.sv
// Small synchronous command FIFO; pointers carry an extra wrap bit so that
// full and empty are told apart without a separate occupancy counter.
module bus_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + PTR_ONE;
      if (pop_i && !empty_o) rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus transfer sequencer: queues src/dst commands, drives the Bus_mux select
// and pulses the destination load enable, with extra wait cycles for MEM.
module bus_xfer_ctrl
  import bus_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_src,
  input  logic [3:0]  cmd_dst,
  output logic [3:0]  mux_sel,
  output logic [15:0] ld_en,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        err_clr
);

  localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT + 1) : 1;

  bus_cmd_t    in_cmd, head, cur_q;
  logic        full, empty, accept, illegal, push, pop, cur_mem;
  xfer_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]  mux_sel_q;
  logic [15:0] ld_en_q;
  logic        mem_rd_q, mem_wr_q, done_q, err_q;

  assign in_cmd    = '{src: cmd_src, dst: cmd_dst};
  assign cmd_ready = !full;
  assign accept    = cmd_valid && cmd_ready;
  assign illegal   = cmd_illegal(in_cmd);
  assign push      = accept && !illegal;
  assign pop       = !empty && ((state_q == S_IDLE) || (state_q == S_LOAD));
  assign cur_mem   = (cur_q.src == CODE_MEM) || (cur_q.dst == CODE_MEM);

  bus_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (in_cmd),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Outputs are assigned on the transition into the state they belong to,
  // so every output is a flop and nothing combinational reaches the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      cnt_q     <= '0;
      mux_sel_q <= '0;
      ld_en_q   <= '0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ld_en_q  <= '0;
      mem_wr_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (pop) begin
            cur_q     <= head;
            mux_sel_q <= head.src;
            mem_rd_q  <= (head.src == CODE_MEM);
            state_q   <= S_DRIVE;
          end else begin
            mux_sel_q <= '0;
            mem_rd_q  <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_DRIVE: begin
          if (cur_mem && (MEM_WAIT > 0)) begin
            cnt_q   <= CNT_W'(MEM_WAIT);
            state_q <= S_WAIT;
          end else begin
            ld_en_q  <= code_onehot(cur_q.dst);
            mem_wr_q <= (cur_q.dst == CODE_MEM);
            done_q   <= 1'b1;
            state_q  <= S_LOAD;
          end
        end
        S_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            ld_en_q  <= code_onehot(cur_q.dst);
            mem_wr_q <= (cur_q.dst == CODE_MEM);
            done_q   <= 1'b1;
            state_q  <= S_LOAD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A new illegal command wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (err_q && !err_clr) || (accept && illegal);
  end

  assign mux_sel = mux_sel_q;
  assign ld_en   = ld_en_q;
  assign mem_rd  = mem_rd_q;
  assign mem_wr  = mem_wr_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: directed scenarios plus random traffic checked
// against a queue-and-segment-length reference model.
module tb_bus_xfer_ctrl;

  localparam int DEPTH    = 4;
  localparam int MEM_WAIT = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, err_clr = 1'b0;
  logic [3:0]  cmd_src = 4'd0, cmd_dst = 4'd0;
  logic        cmd_ready, mem_rd, mem_wr, busy, done, err;
  logic [3:0]  mux_sel;
  logic [15:0] ld_en;

  int vec = 0, errs = 0;

  // Reference model: pending commands, the transfer in flight and the number
  // of cycles it still owns the bus (LOAD is the last one).
  typedef struct { logic [3:0] src; logic [3:0] dst; } cmd_t;
  cmd_t pend[$];
  cmd_t cur;
  int   rem = 0;
  logic m_err = 1'b0;

  logic [3:0]  exp_mux;
  logic [15:0] exp_ld;
  logic        exp_rd, exp_wr, exp_done, exp_busy, exp_ready, exp_err;

  bus_xfer_ctrl #(.DEPTH(DEPTH), .MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .mux_sel(mux_sel), .ld_en(ld_en),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .done(done), .err(err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic void set_exp();
    exp_mux   = (rem != 0) ? cur.src : 4'd0;
    exp_rd    = (rem != 0) && (cur.src == 4'd15);
    exp_ld    = (rem == 1) ? (16'h0001 << cur.dst) : 16'h0000;
    exp_done  = (rem == 1);
    exp_wr    = (rem == 1) && (cur.dst == 4'd15);
    exp_busy  = (rem != 0) || (pend.size() != 0);
    exp_ready = (pend.size() < DEPTH);
    exp_err   = m_err;
  endfunction

  function automatic void model_reset();
    pend.delete();
    rem   = 0;
    m_err = 1'b0;
    set_exp();
  endfunction

  // One clock: inputs held from the previous negedge, model follows the edge.
  task automatic tick();
    logic acc, ill;
    acc = rst_n && cmd_valid && (pend.size() < DEPTH);
    ill = acc && ((cmd_src == 4'd0) || (cmd_dst == 4'd0) || (cmd_src == cmd_dst));
    @(posedge clk);
    if (!rst_n) begin
      pend.delete();
      rem   = 0;
      m_err = 1'b0;
    end else begin
      if (rem > 1) rem--;
      else if (pend.size() > 0) begin
        cur = pend.pop_front();
        rem = 2 + (((cur.src == 4'd15) || (cur.dst == 4'd15)) ? MEM_WAIT : 0);
      end else rem = 0;
      if (acc && !ill) pend.push_back('{cmd_src, cmd_dst});
      m_err = (m_err && !err_clr) || ill;
    end
    @(negedge clk);
    set_exp();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    vec++; if (mux_sel !== 4'd0)    begin errs++; $display("FAIL reset_mux_sel: got %0h expected 0", mux_sel); end
    vec++; if (ld_en !== 16'h0)     begin errs++; $display("FAIL reset_ld_en: got %04h expected 0000", ld_en); end
    vec++; if ({mem_rd, mem_wr, done} !== 3'b000) begin errs++; $display("FAIL reset_strobes: got %03b expected 000", {mem_rd, mem_wr, done}); end
    vec++; if (busy !== 1'b0)       begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vec++; if (cmd_ready !== 1'b1)  begin errs++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    vec++; if (err !== 1'b0)        begin errs++; $display("FAIL reset_err: got %b expected 0", err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ac_dr();
    cmd_valid = 1'b1; cmd_src = 4'd1; cmd_dst = 4'd13;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vec++; if (mux_sel !== ((c == 1 || c == 2) ? 4'd1 : 4'd0)) begin errs++; $display("FAIL acdr_mux_sel c%0d: got %0h", c, mux_sel); end
      vec++; if (ld_en !== ((c == 2) ? 16'h2000 : 16'h0000)) begin errs++; $display("FAIL acdr_ld_en c%0d: got %04h expected %04h", c, ld_en, (c == 2) ? 16'h2000 : 16'h0); end
      vec++; if (done !== (c == 2)) begin errs++; $display("FAIL acdr_done c%0d: got %b expected %b", c, done, c == 2); end
      vec++; if (busy !== (c < 3)) begin errs++; $display("FAIL acdr_busy c%0d: got %b expected %b", c, busy, c < 3); end
      tick();
    end
  endtask

  task automatic test_mem_ar();
    cmd_valid = 1'b1; cmd_src = 4'd15; cmd_dst = 4'd14;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      vec++; if (mem_rd !== (c >= 1 && c <= 4)) begin errs++; $display("FAIL memar_mem_rd c%0d: got %b expected %b", c, mem_rd, c >= 1 && c <= 4); end
      vec++; if (ld_en !== ((c == 4) ? 16'h4000 : 16'h0000)) begin errs++; $display("FAIL memar_ld_en c%0d: got %04h expected %04h", c, ld_en, (c == 4) ? 16'h4000 : 16'h0); end
      vec++; if (mux_sel !== ((c >= 1 && c <= 4) ? 4'd15 : 4'd0)) begin errs++; $display("FAIL memar_mux_sel c%0d: got %0h", c, mux_sel); end
      vec++; if (mem_wr !== 1'b0) begin errs++; $display("FAIL memar_mem_wr c%0d: got %b expected 0", c, mem_wr); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] s [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    logic [3:0] d [8] = '{4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd1, 4'd2};
    logic [3:0] got [8];
    int idx = 0, pulses = 0, last = -1, cyc = 0;
    bit acc, saw_full = 1'b0;
    cmd_valid = 1'b1; cmd_src = s[0]; cmd_dst = d[0];
    while (cyc < 60 && (idx < 8 || rem != 0 || pend.size() != 0)) begin
      acc = cmd_valid && exp_ready;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 8) begin cmd_src = s[idx]; cmd_dst = d[idx]; end
        else cmd_valid = 1'b0;
      end
      vec++; if (cmd_ready !== exp_ready) begin errs++; $display("FAIL b2b_cmd_ready cyc%0d: got %b expected %b", cyc, cmd_ready, exp_ready); end
      vec++; if (ld_en !== exp_ld || mux_sel !== exp_mux) begin errs++; $display("FAIL b2b_bus cyc%0d: got ld %04h sel %0h expected ld %04h sel %0h", cyc, ld_en, mux_sel, exp_ld, exp_mux); end
      if (!cmd_ready) saw_full = 1'b1;
      if (ld_en != 16'h0 && pulses < 8) begin
        got[pulses] = 4'($clog2(ld_en));
        if (last >= 0) begin
          vec++; if (cyc - last != 2) begin errs++; $display("FAIL b2b_spacing pulse%0d: got %0d cycles expected 2", pulses, cyc - last); end
        end
        last = cyc;
        pulses++;
      end
    end
    cmd_valid = 1'b0;
    vec++; if (saw_full !== 1'b1) begin errs++; $display("FAIL b2b_full_seen: got %b expected 1", saw_full); end
    vec++; if (pulses != 8) begin errs++; $display("FAIL b2b_pulse_count: got %0d expected 8", pulses); end
    for (int i = 0; i < 8; i++) begin
      vec++; if (i < pulses && got[i] !== d[i]) begin errs++; $display("FAIL b2b_order #%0d: got dst %0d expected %0d", i, got[i], d[i]); end
    end
  endtask

  task automatic test_err();
    cmd_valid = 1'b1; cmd_src = 4'd0; cmd_dst = 4'd5;
    tick();
    cmd_valid = 1'b0;
    vec++; if (err !== 1'b1) begin errs++; $display("FAIL err_src0: got %b expected 1", err); end
    cmd_valid = 1'b1; cmd_src = 4'd7; cmd_dst = 4'd7;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vec++; if (ld_en !== 16'h0 || done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL err_no_xfer c%0d: got ld %04h done %b busy %b expected 0", c, ld_en, done, busy); end
      vec++; if (err !== 1'b1) begin errs++; $display("FAIL err_sticky c%0d: got %b expected 1", c, err); end
      tick();
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vec++; if (err !== 1'b0) begin errs++; $display("FAIL err_clear: got %b expected 0", err); end
    cmd_valid = 1'b1; cmd_src = 4'd3; cmd_dst = 4'd0;
    tick();
    vec++; if (err !== 1'b1) begin errs++; $display("FAIL err_dst0: got %b expected 1", err); end
    cmd_src = 4'd7; cmd_dst = 4'd7; err_clr = 1'b1;
    tick();
    cmd_valid = 1'b0; err_clr = 1'b0;
    vec++; if (err !== 1'b1) begin errs++; $display("FAIL err_clr_vs_new: got %b expected 1", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_src = 4'd15; cmd_dst = 4'd11;
    tick();
    cmd_src = 4'd1; cmd_dst = 4'd2;
    tick();
    cmd_src = 4'd3; cmd_dst = 4'd4;
    tick();
    cmd_valid = 1'b0;
    vec++; if (mux_sel !== 4'd15 || mem_rd !== 1'b1 || ld_en !== 16'h0) begin errs++; $display("FAIL rstmid_in_wait: got sel %0h rd %b ld %04h expected sel f rd 1 ld 0000", mux_sel, mem_rd, ld_en); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vec++; if ({mux_sel, ld_en} !== 20'h0) begin errs++; $display("FAIL rstmid_bus: got sel %0h ld %04h expected 0", mux_sel, ld_en); end
    vec++; if ({mem_rd, mem_wr, done, busy, err} !== 5'b0) begin errs++; $display("FAIL rstmid_flags: got %05b expected 00000", {mem_rd, mem_wr, done, busy, err}); end
    vec++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rstmid_cmd_ready: got %b expected 1", cmd_ready); end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      vec++; if (ld_en !== 16'h0 || done !== 1'b0 || mem_wr !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rstmid_after c%0d: got ld %04h done %b wr %b busy %b expected all 0", c, ld_en, done, mem_wr, busy); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      cmd_valid = ($urandom_range(0, 99) < 60);
      cmd_src   = 4'($urandom_range(0, 15));
      cmd_dst   = 4'($urandom_range(0, 15));
      err_clr   = ($urandom_range(0, 19) == 0);
      tick();
      vec++;
      if ({mux_sel, ld_en, mem_rd, mem_wr, done, busy, cmd_ready, err} !==
          {exp_mux, exp_ld, exp_rd, exp_wr, exp_done, exp_busy, exp_ready, exp_err}) begin
        errs++;
        $display("FAIL random #%0d: got sel %0h ld %04h rd %b wr %b done %b busy %b rdy %b err %b expected sel %0h ld %04h rd %b wr %b done %b busy %b rdy %b err %b",
                 i, mux_sel, ld_en, mem_rd, mem_wr, done, busy, cmd_ready, err,
                 exp_mux, exp_ld, exp_rd, exp_wr, exp_done, exp_busy, exp_ready, exp_err);
      end
    end
    cmd_valid = 1'b0; err_clr = 1'b0;
    repeat (40) tick();
    vec++; if (busy !== 1'b0 || exp_busy !== 1'b0) begin errs++; $display("FAIL random_drain: got busy %b model busy %b expected 0", busy, exp_busy); end
  endtask

  initial begin
    set_exp();
    test_reset();
    test_ac_dr();
    test_mem_ar();
    test_back_to_back();
    test_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1);
  end

endmodule

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

Sequencer for the shared 8-bit datapath bus. It accepts register-to-register transfer commands (source code, destination code) into a small queue. For each command it drives the Bus_mux select and pulses the one-hot load enable of the destination register. Memory-sourced or memory-destined transfers get extra wait cycles. It sits between the control unit and the Bus_mux/register file, and is the only driver of the bus select.

## Interface
- DEPTH, 4: command queue depth, power of two, ≥2
- MEM_WAIT, 1: extra cycles held in WAIT when source or destination is MEM (0 allowed)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue can accept; equals !full
- cmd_src  in  4  source code (1 AC, 2 C3, 3 C2, 4 C1, 5 RN2, 6 RK2, 7 RM2, 8 RN1, 9 RK1, 10 RM1, 11 RT, 12 RP, 13 DR, 14 AR, 15 MEM)
- cmd_dst  in  4  destination code, same encoding
- mux_sel  out  4  to Bus_mux select; 0 = bus idle
- ld_en  out  16  one-hot load enable, bit n = code n; bit 0 never set
- mem_rd  out  1  memory read strobe (source = 15)
- mem_wr  out  1  memory write strobe (destination = 15)
- busy  out  1  FSM not in IDLE, or queue non-empty
- done  out  1  one-cycle pulse in the LOAD cycle
- err  out  1  sticky illegal-command flag
- err_clr  in  1  clears err

## Operation
- Handshake: a command is accepted on a rising edge with cmd_valid && cmd_ready. cmd_ready depends only on full, so there is no push into a full queue even when a pop happens in the same cycle.
- Illegal command: src=0, dst=0 or src==dst. It is accepted but not queued, and err is set on that edge. If err_clr and a new error occur together, err stays 1.
- FSM states:
  - IDLE: mux_sel=0. If the queue is non-empty, pop the head into cur_src/cur_dst and go to DRIVE.
  - DRIVE: mux_sel=cur_src; mem_rd=(cur_src==15). If cur_src or cur_dst is 15 and MEM_WAIT>0, load the counter with MEM_WAIT and go to WAIT. Otherwise go to LOAD.
  - WAIT: hold mux_sel and mem_rd. Decrement the counter; go to LOAD when it reaches 1.
  - LOAD: hold mux_sel and mem_rd. ld_en[cur_dst]=1, mem_wr=(cur_dst==15), done=1. If the queue is non-empty, pop and go to DRIVE (back-to-back). Otherwise go to IDLE.
- Commands execute strictly in acceptance order, each exactly once.
- Reset values: all outputs 0 except cmd_ready=1. The queue is empty and the FSM is in IDLE.
- Reset asserted mid-transfer: the transfer is abandoned and the queue flushed. No ld_en, mem_wr or done is produced from it, before or after release.

## Timing
- Latency: for a command accepted at edge 0 with the FSM idle, the pop happens at edge 1 and DRIVE occupies cycle 1. LOAD occupies cycle 2 (ld_en high), and the destination captures at edge 3.
- MEM transfers add exactly MEM_WAIT cycles.
- Throughput: one non-MEM transfer per 2 cycles, with no idle cycle between queued transfers.
- mux_sel is stable from DRIVE through LOAD inclusive. ld_en is high for exactly one cycle and only in LOAD, so the bus is settled at least one full cycle before capture.
- All outputs are registered or decoded from registered state only. There is no combinational path from cmd_* to any output.

## Structure
- Package bus_pkg holds:
  - the 4-bit source/destination code constants, shared with Bus_mux and the register file;
  - the FSM state encoding;
  - the MEM code value 15.
- Sub-module bus_cmd_fifo: DEPTH×8-bit synchronous FIFO with async active-low reset and full/empty flags. Pointers carry one extra wrap bit.
- The top level holds the FSM, wait counter, ld_en one-hot decode and err logic.

## Test plan
- Reset: hold rst_n=0 → mux_sel=0, ld_en=0, mem_rd=mem_wr=0, busy=0, cmd_ready=1, err=0.
- AC→DR (src 1, dst 13), accepted at edge 0 → mux_sel=1 in cycles 1–2, ld_en=16'h2000 and done=1 in cycle 2 only, then back to IDLE.
- MEM→AR (15, 14) with MEM_WAIT=2 → mem_rd high for 4 cycles. ld_en=16'h4000 in cycle 4, 2 cycles later than the previous case; mem_wr stays 0.
- Eight distinct legal commands offered back-to-back → cmd_ready low whenever 4 entries are queued. All 8 execute in order, one ld_en pulse each, 2 cycles apart.
- Commands (0, 5) and (7, 7) → err=1 with no ld_en. err_clr alone → err=0. err_clr together with a new illegal command → err remains 1.
- Assert rst_n=0 during WAIT of a MEM→RT transfer with 2 commands queued → outputs return to reset values immediately. No ld_en or done appears after release.
